// File: rtl/pwm_meter.sv
// pwm_meter: measures high time and period of an external PWM line in prescaled ticks
module pwm_meter #(
  parameter int PRESCALE = 50001,
  parameter int TIMEOUT  = 65535
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pwm_in,
  output logic [14:0] high_ticks,
  output logic [15:0] period_ticks,
  output logic        meas_valid,
  output logic        locked,
  output logic        stuck_level,
  output logic [6:0]  ss1,
  output logic [6:0]  ss2,
  output logic [6:0]  ss3,
  output logic [6:0]  ss4,
  output logic        diod
);
  localparam int DW = $clog2(PRESCALE);
  typedef enum logic [1:0] {WAIT_RISE, MEAS_HIGH, MEAS_LOW} state_t;
  state_t state_q, state_d;
  logic [2:0] sync_q;
  logic [DW-1:0] div_q;
  logic [15:0] idle_q, idle_d, pcnt_q, pcnt_d, period_q, period_d, pinc;
  logic [14:0] hcnt_q, hcnt_d, high_q, high_d, hinc;
  logic valid_q, valid_d, locked_q, locked_d, stuck_q, stuck_d;
  logic pwm_s, pwm_d, rise, fall, tick, timeout;
  function automatic logic [6:0] seg7(input logic [3:0] h);
    case (h)
      4'h0: seg7 = 7'h40;
      4'h1: seg7 = 7'h79;
      4'h2: seg7 = 7'h24;
      4'h3: seg7 = 7'h30;
      4'h4: seg7 = 7'h19;
      4'h5: seg7 = 7'h12;
      4'h6: seg7 = 7'h02;
      4'h7: seg7 = 7'h78;
      4'h8: seg7 = 7'h00;
      4'h9: seg7 = 7'h10;
      4'ha: seg7 = 7'h08;
      4'hb: seg7 = 7'h03;
      4'hc: seg7 = 7'h46;
      4'hd: seg7 = 7'h21;
      4'he: seg7 = 7'h06;
      default: seg7 = 7'h0e;
    endcase
  endfunction
  assign pwm_s   = sync_q[1];
  assign pwm_d   = sync_q[2];
  assign rise    = pwm_s & ~pwm_d;
  assign fall    = ~pwm_s & pwm_d;
  assign tick    = div_q == DW'(PRESCALE - 1);
  // an edge in the same cycle means the line is alive, so it wins over timeout
  assign timeout = tick & ~(rise | fall) & (idle_q == 16'(TIMEOUT - 1));
  assign hinc    = hcnt_q + 15'(tick & ~&hcnt_q);
  assign pinc    = pcnt_q + 16'(tick & ~&pcnt_q);
  always_comb begin
    state_d  = state_q;
    hcnt_d   = hcnt_q;
    pcnt_d   = pcnt_q;
    high_d   = high_q;
    period_d = period_q;
    valid_d  = 1'b0;
    locked_d = locked_q;
    stuck_d  = stuck_q;
    idle_d   = (rise | fall) ? 16'd0 : idle_q + 16'(tick);
    if (timeout) begin
      locked_d = 1'b0;
      stuck_d  = pwm_s;
      high_d   = '0;
      period_d = '0;
      state_d  = WAIT_RISE;
      idle_d   = '0;
    end else begin
      case (state_q)
        WAIT_RISE: begin
          state_d = rise ? MEAS_HIGH : WAIT_RISE;
          hcnt_d  = rise ? '0 : hcnt_q;
          pcnt_d  = rise ? '0 : pcnt_q;
        end
        MEAS_HIGH: begin
          hcnt_d  = hinc;
          pcnt_d  = pinc;
          state_d = fall ? MEAS_LOW : MEAS_HIGH;
        end
        MEAS_LOW: begin
          pcnt_d = pinc;
          if (rise) begin
            high_d   = hcnt_q;
            period_d = pinc;
            valid_d  = 1'b1;
            locked_d = 1'b1;
            hcnt_d   = '0;
            pcnt_d   = '0;
            state_d  = MEAS_HIGH;
          end
        end
        default: state_d = WAIT_RISE;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q   <= '0;
      div_q    <= '0;
      state_q  <= WAIT_RISE;
      idle_q   <= '0;
      hcnt_q   <= '0;
      pcnt_q   <= '0;
      high_q   <= '0;
      period_q <= '0;
      valid_q  <= 1'b0;
      locked_q <= 1'b0;
      stuck_q  <= 1'b0;
    end else begin
      sync_q   <= {sync_q[1:0], pwm_in};
      div_q    <= tick ? '0 : div_q + 1'b1;
      state_q  <= state_d;
      idle_q   <= idle_d;
      hcnt_q   <= hcnt_d;
      pcnt_q   <= pcnt_d;
      high_q   <= high_d;
      period_q <= period_d;
      valid_q  <= valid_d;
      locked_q <= locked_d;
      stuck_q  <= stuck_d;
    end
  end
  assign high_ticks   = high_q;
  assign period_ticks = period_q;
  assign meas_valid   = valid_q;
  assign locked       = locked_q;
  assign stuck_level  = stuck_q;
  assign diod         = locked_q;
  assign ss1          = seg7(high_q[3:0]);
  assign ss2          = seg7(high_q[7:4]);
  assign ss3          = seg7(high_q[11:8]);
  assign ss4          = seg7({2'b00, high_q[13:12]});
endmodule

// File: tb/tb_pwm_meter.sv
// tb_pwm_meter: directed PWM stimulus with a scoreboard of expected measurements
module tb_pwm_meter;
  logic clk = 1'b0, reset = 1'b1, pwm_in = 1'b0;
  always #5 clk = ~clk;
  logic [14:0] m4_h, m2_h, mt_h;
  logic [15:0] m4_p, m2_p, mt_p;
  logic m4_v, m4_l, m4_s, m4_d, m2_v, m2_l, m2_s, m2_d, mt_v, mt_l, mt_s, mt_d;
  logic [6:0] m4_ss1, m4_ss2, m4_ss3, m4_ss4, m2_ss1, m2_ss2, m2_ss3, m2_ss4;
  logic [6:0] mt_ss1, mt_ss2, mt_ss3, mt_ss4;
  pwm_meter #(.PRESCALE(4), .TIMEOUT(65535)) u_m4 (
    .clk(clk), .reset(reset), .pwm_in(pwm_in), .high_ticks(m4_h), .period_ticks(m4_p),
    .meas_valid(m4_v), .locked(m4_l), .stuck_level(m4_s), .ss1(m4_ss1), .ss2(m4_ss2),
    .ss3(m4_ss3), .ss4(m4_ss4), .diod(m4_d));
  pwm_meter #(.PRESCALE(2), .TIMEOUT(65535)) u_m2 (
    .clk(clk), .reset(reset), .pwm_in(pwm_in), .high_ticks(m2_h), .period_ticks(m2_p),
    .meas_valid(m2_v), .locked(m2_l), .stuck_level(m2_s), .ss1(m2_ss1), .ss2(m2_ss2),
    .ss3(m2_ss3), .ss4(m2_ss4), .diod(m2_d));
  pwm_meter #(.PRESCALE(2), .TIMEOUT(8)) u_mt (
    .clk(clk), .reset(reset), .pwm_in(pwm_in), .high_ticks(mt_h), .period_ticks(mt_p),
    .meas_valid(mt_v), .locked(mt_l), .stuck_level(mt_s), .ss1(mt_ss1), .ss2(mt_ss2),
    .ss3(mt_ss3), .ss4(mt_ss4), .diod(mt_d));
  int n_chk = 0, n_fail = 0, ign = 0;
  int prev_hi = 0, prev_lo = 0;
  bit armed = 1'b0;
  logic prev_v = 1'b0;
  logic [30:0] q[$];
  logic [30:0] e;
  function automatic logic [30:0] model(input int hi, input int lo);
    int h, p;
    h = hi / 2;
    p = (hi + lo) / 2;
    if (h > 32767) h = 32767;
    if (p > 65535) p = 65535;
    return {h[14:0], p[15:0]};
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic seg(input logic v, input int n);
    pwm_in = v;
    repeat (n) @(negedge clk);
  endtask
  task automatic push_prev();
    if (armed) q.push_back(model(prev_hi, prev_lo));
  endtask
  task automatic period(input int hi, input int lo);
    push_prev();
    seg(1'b1, hi);
    seg(1'b0, lo);
    prev_hi = hi;
    prev_lo = lo;
    armed = 1'b1;
  endtask
  always @(negedge clk) begin
    if (m2_v) begin
      n_chk++;
      assert (!prev_v) else begin
        n_fail++;
        $error("FAIL m2_valid_width: got 2+ cycles expected 1");
      end
      if (ign > 0) ign--;
      else begin
        n_chk++;
        assert (q.size() > 0) else begin
          n_fail++;
          $error("FAIL m2_unexpected_valid: got pulse h=%0d p=%0d expected none", m2_h, m2_p);
        end
        if (q.size() > 0) begin
          e = q.pop_front();
          n_chk++;
          assert ({m2_h, m2_p} === e) else begin
            n_fail++;
            $error("FAIL m2_meas: got h=%0d p=%0d expected h=%0d p=%0d", m2_h, m2_p, e[30:16], e[15:0]);
          end
        end
      end
    end
    prev_v <= m2_v;
  end
  initial begin
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("rst_high", 32'(m2_h), 0);
    chk("rst_period", 32'(m2_p), 0);
    chk("rst_valid", 32'(m2_v), 0);
    chk("rst_locked", 32'(m2_l), 0);
    chk("rst_stuck", 32'(m2_s), 0);
    chk("rst_diod", 32'(m2_d), 0);
    chk("rst_ss", {4'h0, m2_ss4, m2_ss3, m2_ss2, m2_ss1}, {4'h0, 7'h40, 7'h40, 7'h40, 7'h40});
    for (int i = 0; i < 4; i++) period(12, 16);
    chk("p4_high", 32'(m4_h), 3);
    chk("p4_period", 32'(m4_p), 7);
    chk("p4_locked", 32'(m4_l), 1);
    chk("p4_diod", 32'(m4_d), 1);
    chk("p4_ss", {4'h0, m4_ss4, m4_ss3, m4_ss2, m4_ss1}, {4'h0, 7'h40, 7'h40, 7'h40, 7'h30});
    for (int i = 0; i < 3; i++) period(10, 30);
    chk("p2_high", 32'(m2_h), 5);
    chk("p2_locked", 32'(m2_l), 1);
    chk("p2_ss", {4'h0, m2_ss4, m2_ss3, m2_ss2, m2_ss1}, {4'h0, 7'h40, 7'h40, 7'h40, 7'h12});
    push_prev();
    seg(1'b1, 10);
    seg(1'b0, 10);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("mid_rst_high", 32'(m2_h), 0);
    chk("mid_rst_period", 32'(m2_p), 0);
    chk("mid_rst_locked", 32'(m2_l), 0);
    chk("mid_rst_ss1", 32'(m2_ss1), 32'h40);
    armed = 1'b0;
    seg(1'b0, 10);
    period(10, 30);
    chk("rearm_locked", 32'(m2_l), 0);
    period(10, 30);
    chk("relock_locked", 32'(m2_l), 1);
    push_prev();
    seg(1'b1, 10);
    seg(1'b0, 12);
    ign = 2;
    seg(1'b1, 1);
    seg(1'b0, 17);
    armed = 1'b0;
    period(10, 30);
    period(10, 30);
    for (int i = 0; i < 3; i++) period(6, 8);
    chk("to_pre_locked", 32'(mt_l), 1);
    chk("to_pre_high", 32'(mt_h), 3);
    chk("to_pre_period", 32'(mt_p), 7);
    push_prev();
    seg(1'b1, 22);
    chk("to_locked", 32'(mt_l), 0);
    chk("to_diod", 32'(mt_d), 0);
    chk("to_stuck", 32'(mt_s), 1);
    chk("to_high", 32'(mt_h), 0);
    chk("to_period", 32'(mt_p), 0);
    chk("to_other_locked", 32'(m2_l), 1);
    seg(1'b1, 18);
    seg(1'b0, 8);
    prev_hi = 40;
    prev_lo = 8;
    period(6, 8);
    chk("to_first_rise_locked", 32'(mt_l), 0);
    period(6, 8);
    chk("to_second_rise_locked", 32'(mt_l), 1);
    chk("to_relock_high", 32'(mt_h), 3);
    push_prev();
    seg(1'b1, 70000);
    seg(1'b0, 2);
    prev_hi = 70000;
    prev_lo = 2;
    period(10, 30);
    chk("sat_high", 32'(m2_h), 32767);
    chk("sat_period", 32'(m2_p), 35001);
    chk("sat_ss", {4'h0, m2_ss4, m2_ss3, m2_ss2, m2_ss1}, {4'h0, 7'h30, 7'h0e, 7'h0e, 7'h0e});
    push_prev();
    seg(1'b1, 4);
    seg(1'b0, 6);
    chk("queue_empty", 32'(q.size()), 0);
    chk("ignore_used", 32'(ign), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
